// File: rtl/bus_sink_pkg.sv
// Shared bus definitions: default widths, sink FSM encoding and the source-side beat type.
package bus_sink_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int BUS_DEPTH  = 4;
    localparam int BUS_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } sink_state_e;

    // What a source presents on the link in one cycle.
    typedef struct packed {
        logic                  valid;
        logic [BUS_DATA_W-1:0] data;
    } src_beat_t;

endpackage

// File: rtl/bus_sink_fifo.sv
// Show-ahead FIFO: storage, wrapping pointers and occupancy count.
module bus_sink_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              not_empty,
    output logic              not_full,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign not_full  = (count_reg < FULL_CNT);
    assign not_empty = (count_reg != '0);
    assign push_ok   = push && not_full;
    assign pop_ok    = pop && not_empty;
    assign count     = count_reg;
    assign head_data = not_empty ? mem[rd_ptr_reg] : '0;

    // Storage is deliberately left unreset; the empty gate hides stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bus_sink.sv
// Valid/ready sink: buffers beats in a FIFO, measures bursts and flags withdrawn beats.
module bus_sink
    import bus_sink_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int DEPTH  = BUS_DEPTH,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid_i,
    input  logic [DATA_W-1:0]        s_data_i,
    output logic                     s_ready_o,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     burst_done_o,
    output logic [LEN_W-1:0]         burst_len_o,
    output logic                     err_o
);

    sink_state_e      state_reg;
    sink_state_e      state_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] burst_len_reg;
    logic             burst_done_reg;
    logic             err_reg;
    logic             accept;
    logic             burst_end;
    logic             withdraw;
    logic             leave_idle;

    bus_sink_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (s_data_i),
        .pop       (rd_en_i),
        .head_data (rd_data_o),
        .not_empty (rd_valid_o),
        .not_full  (s_ready_o),
        .count     (count_o)
    );

    assign accept     = s_valid_i && s_ready_o;
    assign leave_idle = (state_reg == ST_IDLE) && (state_next != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        burst_end  = 1'b0;
        withdraw   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_RECV;
                end else if (s_valid_i) begin
                    state_next = ST_HOLD;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    state_next = ST_RECV;
                end else if (s_valid_i) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_IDLE;
                    burst_end  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_next = ST_RECV;
                end else if (!s_valid_i) begin
                    // The source gave up on a beat it had offered.
                    state_next = ST_IDLE;
                    burst_end  = 1'b1;
                    withdraw   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            len_reg        <= '0;
            burst_len_reg  <= '0;
            burst_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            burst_done_reg <= burst_end;
            if (leave_idle) begin
                len_reg <= accept ? LEN_W'(1) : '0;
            end else if (accept && (len_reg != '1)) begin
                len_reg <= len_reg + LEN_W'(1);
            end
            if (burst_end) begin
                burst_len_reg <= len_reg;
            end
            if (withdraw) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign burst_done_o = burst_done_reg;
    assign burst_len_o  = burst_len_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_bus_sink.sv
// Randomised and directed bench for bus_sink against a queue-based burst model.
module tb_bus_sink;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 8;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   s_valid_i = 1'b0;
    logic [DATA_W-1:0]      s_data_i = '0;
    logic                   s_ready_o;
    logic                   rd_en_i = 1'b0;
    logic [DATA_W-1:0]      rd_data_o;
    logic                   rd_valid_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   burst_done_o;
    logic [LEN_W-1:0]       burst_len_o;
    logic                   err_o;

    int checks = 0;
    int errors = 0;

    // Model: FIFO contents, whether a burst is open, whether a beat is pending unaccepted.
    logic [DATA_W-1:0] q[$];
    bit m_busy, m_pending, m_done, m_err;
    int m_len, m_blen;

    bus_sink #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .rd_en_i      (rd_en_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .count_o      (count_o),
        .burst_done_o (burst_done_o),
        .burst_len_o  (burst_len_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DATA_W-1:0] head;
        head = (q.size() > 0) ? q[0] : '0;
        check("count",      32'(count_o),      32'(q.size()));
        check("rd_valid",   32'(rd_valid_o),   32'(q.size() > 0));
        check("rd_data",    32'(rd_data_o),    32'(head));
        check("s_ready",    32'(s_ready_o),    32'(q.size() < DEPTH));
        check("burst_done", 32'(burst_done_o), 32'(m_done));
        check("burst_len",  32'(burst_len_o),  32'(m_blen));
        check("err",        32'(err_o),        32'(m_err));
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_pending = 0; m_done = 0; m_err = 0;
        m_len = 0; m_blen = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid_i = 1'b0;
        rd_en_i   = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        $display("reset asserted");
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of stimulus; the model decides the outcome from the pre-edge state.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
        bit ready, acc, popq;
        @(negedge clk);
        s_valid_i = v;
        s_data_i  = d;
        rd_en_i   = r;
        ready = (q.size() < DEPTH);
        acc   = v && ready;
        popq  = r && (q.size() > 0);
        m_done = 0;
        if (!m_busy) begin
            if (v) begin
                m_busy    = 1;
                m_len     = acc ? 1 : 0;
                m_pending = !acc;
            end
        end else if (acc) begin
            if (m_len < LEN_MAX) m_len++;
            m_pending = 0;
        end else if (v) begin
            m_pending = 1;
        end else begin
            m_done = 1;
            if (m_pending) m_err = 1;
            m_blen    = m_len;
            m_busy    = 0;
            m_pending = 0;
        end
        if (popq) void'(q.pop_front());
        if (acc) q.push_back(d);
        @(posedge clk);
        #1;
        $display("step v=%0d d=%02h r=%0d acc=%0d pop=%0d count=%0d done=%0d len=%0d err=%0d",
                 v, d, r, acc, popq, count_o, burst_done_o, burst_len_o, err_o);
        check_outputs();
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        model_reset();
        #12;
        do_reset();

        // Three beats then valid drops: burst of 3, head is first beat.
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

        // Six beats offered into a depth-4 FIFO, then a single pop frees a slot.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1, 8'(8'hA0 + i), 0);
        step(1, 8'hA5, 0);
        step(1, 8'hA5, 1);
        step(1, 8'hA5, 0);
        step(1, 8'hA6, 0);
        // Full with valid and rd_en both held: order must be kept.
        d = 8'hA6;
        for (int i = 0; i < 10; i++) begin
            step(1, d, 1);
            if (q.size() > 0 && q[q.size()-1] == d) d = d + 8'h1;
        end
        step(0, 8'h00, 0);

        // Full FIFO, pending beat withdrawn: sticky error, burst of 4.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 0);
        step(1, 8'h54, 0);
        step(0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);

        // Reset mid-burst discards everything with no done pulse.
        do_reset();
        step(1, 8'h77, 0);
        step(1, 8'h78, 0);
        do_reset();
        step(0, 8'h00, 0);

        // Pops on an empty FIFO are ignored.
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(1, 8'h99, 0);
        step(0, 8'h00, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
